// File: rtl/demux_stream_n_if.sv
// demux_stream_n_if: producer/consumer bundle for the 1-to-N stream demultiplexer
interface demux_stream_n_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 8,
   parameter int SELW  = 3
);
   logic [WIDTH-1:0] i_data;
   logic             i_valid;
   logic             i_ready;
   logic [SELW-1:0]  s;
   logic             mode;
   logic [WIDTH-1:0] o_data;
   logic [NCH-1:0]   o_valid;
   logic [NCH-1:0]   o_ready;
   logic [SELW-1:0]  cur_sel;
   logic             err;
   modport master (
      output i_data, i_valid, s, mode, o_ready,
      input  i_ready, o_data, o_valid, cur_sel, err
   );
   modport slave (
      input  i_data, i_valid, s, mode, o_ready,
      output i_ready, o_data, o_valid, cur_sel, err
   );
endinterface

// File: rtl/demux_stream_n.sv
// demux_stream_n: registered 1-to-N stream demux with one-entry hold, backpressure and round-robin mode
module demux_stream_n #(
   parameter int WIDTH = 8,
   parameter int NCH   = 8,
   parameter int SELW  = 3
) (
   input logic clk,
   input logic rst,
   demux_stream_n_if.slave bus
);
   logic             hold_valid;
   logic [SELW-1:0]  hold_sel;
   logic [WIDTH-1:0] hold_data;
   logic [SELW-1:0]  rr_sel;
   logic             err_q;
   logic [SELW-1:0]  sel;
   logic             in_range;
   logic             in_xfer;
   logic             out_xfer;
   assign out_xfer    = hold_valid && bus.o_ready[hold_sel];
   assign bus.i_ready = !rst && (!hold_valid || bus.o_ready[hold_sel]);
   assign in_xfer     = bus.i_valid && bus.i_ready;
   assign sel         = bus.mode ? rr_sel : bus.s;
   assign in_range    = 32'(sel) < NCH;
   assign bus.o_data  = hold_data;
   assign bus.o_valid = hold_valid ? NCH'(1) << hold_sel : '0;
   assign bus.cur_sel = rr_sel;
   assign bus.err     = err_q;
   // load/replace/drain the hold register, advance the round-robin pointer, flag dropped beats
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_sel   <= '0;
         hold_data  <= '0;
         rr_sel     <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= in_xfer && !in_range;
         if (in_xfer && in_range) begin
            hold_data  <= bus.i_data;
            hold_sel   <= sel;
            hold_valid <= 1'b1;
         end else if (out_xfer) begin
            hold_valid <= 1'b0;
         end
         if (in_xfer && bus.mode)
            rr_sel <= (32'(rr_sel) == NCH - 1) ? '0 : rr_sel + SELW'(1);
      end
   end
endmodule

// File: tb/tb_demux_stream_n.sv
// tb_demux_stream_n: directed plus random checks of two demux instances (8 and 6 channels) against a stream model
module tb_demux_stream_n;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   demux_stream_n_if #(.WIDTH(8), .NCH(8), .SELW(3)) a ();
   demux_stream_n_if #(.WIDTH(8), .NCH(6), .SELW(3)) b ();
   demux_stream_n #(.WIDTH(8), .NCH(8), .SELW(3)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
   demux_stream_n #(.WIDTH(8), .NCH(6), .SELW(3)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

   int errors = 0;
   int checks = 0;
   int nch [2] = '{8, 6};

   logic       iv   [2];
   logic [7:0] id   [2];
   logic [2:0] is   [2];
   logic       im   [2];
   logic [7:0] ordy [2];

   assign a.i_valid = iv[0];
   assign a.i_data  = id[0];
   assign a.s       = is[0];
   assign a.mode    = im[0];
   assign a.o_ready = ordy[0];
   assign b.i_valid = iv[1];
   assign b.i_data  = id[1];
   assign b.s       = is[1];
   assign b.mode    = im[1];
   assign b.o_ready = ordy[1][5:0];

   logic [7:0] ov [2];
   logic [7:0] od [2];
   logic [2:0] oc [2];
   logic       oe [2];
   logic       ori[2];
   assign ov[0] = a.o_valid;
   assign ov[1] = {2'b00, b.o_valid};
   assign od[0] = a.o_data;
   assign od[1] = b.o_data;
   assign oc[0] = a.cur_sel;
   assign oc[1] = b.cur_sel;
   assign oe[0] = a.err;
   assign oe[1] = b.err;
   assign ori[0] = a.i_ready;
   assign ori[1] = b.i_ready;

   // model: whether a beat is waiting, which channel it is for, its data, the next round-robin channel, last drop
   bit         mv [2];
   int         mc [2];
   logic [7:0] md [2];
   int         mr [2];
   bit         me [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mv[d] = 0; mc[d] = 0; md[d] = 8'h00; mr[d] = 0; me[d] = 0;
      end
   endtask

   function automatic bit can_take(int d);
      return !mv[d] || ordy[d][mc[d]];
   endfunction

   // one clock: check readiness before the edge, advance the model at the edge, check registered outputs after it
   task automatic tick();
      #1;
      for (int d = 0; d < 2; d++) chk($sformatf("i_ready[%0d]", d), ori[d], rst ? 0 : can_take(d));
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         automatic bit taken = iv[d] && can_take(d);
         automatic bit drained = mv[d] && ordy[d][mc[d]];
         automatic int sel = im[d] ? mr[d] : int'(is[d]);
         me[d] = taken && sel >= nch[d];
         if (taken && sel < nch[d]) begin
            mv[d] = 1; mc[d] = sel; md[d] = id[d];
         end else if (drained) mv[d] = 0;
         if (taken && im[d]) mr[d] = (mr[d] + 1) % nch[d];
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("o_valid[%0d]", d), ov[d], mv[d] ? (32'd1 << mc[d]) : 32'd0);
         chk($sformatf("o_data[%0d]", d), od[d], md[d]);
         chk($sformatf("cur_sel[%0d]", d), oc[d], mr[d]);
         chk($sformatf("err[%0d]", d), oe[d], me[d]);
      end
      @(negedge clk);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         iv[d] = 0; id[d] = 0; is[d] = 0; im[d] = 0; ordy[d] = 8'hFF;
      end
      model_reset();
      #1;
      chk("reset_ready", a.i_ready, 0);
      chk("reset_ovalid", a.o_valid, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tick();
      chk("reset_odata", a.o_data, 0);
      chk("reset_cursel", a.cur_sel, 0);

      // addressed sweep at full throughput
      iv[0] = 1; id[0] = 8'hA5;
      for (int k = 0; k < 8; k++) begin
         is[0] = 3'(k);
         tick();
         chk("sweep_ovalid", a.o_valid, 32'd1 << k);
         chk("sweep_odata", a.o_data, 8'hA5);
      end
      iv[0] = 0;
      tick();

      // backpressure on channel 3
      is[0] = 3; id[0] = 8'h3C; iv[0] = 1;
      tick();
      ordy[0] = 8'hF7; id[0] = 8'h5A;
      repeat (4) begin
         tick();
         chk("bp_hold_ovalid", a.o_valid, 8'h08);
         chk("bp_hold_odata", a.o_data, 8'h3C);
      end
      #1 chk("bp_ready_low", a.i_ready, 0);
      ordy[0] = 8'hFF;
      tick();
      chk("bp_replace_odata", a.o_data, 8'h5A);
      iv[0] = 0;
      tick();

      // round-robin wrap over ten beats
      im[0] = 1; iv[0] = 1;
      for (int k = 0; k < 10; k++) begin
         id[0] = 8'(k);
         tick();
         chk("rr_ovalid", a.o_valid, 32'd1 << (k % 8));
         chk("rr_odata", a.o_data, k);
      end
      iv[0] = 0;
      tick();
      chk("rr_cursel_end", a.cur_sel, 2);

      // out-of-range select on the 6-channel instance
      is[1] = 7; id[1] = 8'h11; iv[1] = 1;
      tick();
      chk("oor_err", b.err, 1);
      chk("oor_ovalid", b.o_valid, 0);
      is[1] = 5; id[1] = 8'h22;
      tick();
      chk("oor_err_clear", b.err, 0);
      chk("oor_next_ovalid", b.o_valid, 6'b100000);
      iv[1] = 0;
      tick();

      // reset in the middle of a stalled beat
      iv[0] = 1;
      repeat (3) tick();
      chk("pre_reset_cursel", a.cur_sel, 5);
      im[0] = 0; is[0] = 2; id[0] = 8'h77; ordy[0] = 8'hFB;
      tick();
      iv[0] = 0;
      tick();
      chk("pre_reset_ovalid", a.o_valid, 8'h04);
      #2 rst = 1'b1;
      #1;
      chk("async_ovalid", a.o_valid, 0);
      chk("async_cursel", a.cur_sel, 0);
      chk("async_ready", a.i_ready, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      im[0] = 1; iv[0] = 1; id[0] = 8'h99; ordy[0] = 8'hFF;
      tick();
      chk("post_reset_ovalid", a.o_valid, 8'h01);
      iv[0] = 0;
      tick();

      // random traffic on both instances
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 2; d++) begin
            iv[d]   = 1'($urandom_range(0, 3) != 0);
            id[d]   = 8'($urandom);
            is[d]   = 3'($urandom);
            im[d]   = 1'($urandom_range(0, 3) == 0);
            ordy[d] = 8'($urandom) | 8'($urandom);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/demux_stream_n.md
Name: demux_stream_n

Overview:
- Parametrised, registered 1-to-N demultiplexer with valid/ready handshake. Generalises the combinational 1-to-8 demux to arbitrary data width and channel count.
- Adds a one-entry output holding register with per-channel backpressure and a round-robin auto-select mode.
- Sits between a single stream producer and NCH consumers, e.g. distributing samples to parallel processing lanes.

Parameters:
- WIDTH, 8, data width in bits.
- NCH, 8, number of output channels (2..256).
- SELW, 3, select width; must satisfy 2**SELW >= NCH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_data  input  WIDTH  input data beat.
- i_valid  input  1  input beat valid.
- i_ready  output  1  block can accept a beat this cycle.
- s  input  SELW  channel select, used in mode 0 and sampled at input transfer.
- mode  input  1  0 = addressed by s; 1 = round-robin.
- o_data  output  WIDTH  held data, common to all channels.
- o_valid  output  NCH  one-hot valid; bit k means o_data is for channel k.
- o_ready  input  NCH  per-channel consumer ready.
- cur_sel  output  SELW  round-robin pointer (next channel in mode 1).
- err  output  1  one-cycle pulse when an out-of-range select is dropped.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high. On rst assertion, immediately:
  - hold_valid = 0, o_valid = 0, o_data = 0
  - hold_sel = 0, cur_sel = 0, err = 0
- i_ready is forced 0 while rst is high.
- Internal state: hold_valid, hold_sel[SELW], hold_data[WIDTH].
- i_ready = !rst && (!hold_valid || o_ready[hold_sel]). Combinational, so the block sustains one beat per cycle when the consumer is ready.
- Input transfer: i_valid && i_ready at a rising clk edge.
- Output transfer: o_valid[k] && o_ready[k] at a rising clk edge.
- Effective select at input transfer: sel = (mode ? cur_sel : s).
- On input transfer with sel < NCH:
  - hold_data <= i_data, hold_sel <= sel, hold_valid <= 1.
  - Latency is exactly 1 cycle: the beat appears on o_data/o_valid in the cycle after acceptance.
- On input transfer with sel >= NCH (only reachable when NCH is not a power of 2):
  - The beat is accepted and discarded; err = 1 for the following cycle.
  - hold_valid <= 0 if the held beat drained this cycle, otherwise unchanged.
- Output transfer with no simultaneous input transfer: hold_valid <= 0.
- Simultaneous output and input transfer: the new beat replaces the held one with no bubble.
- Held beat not consumed: o_data, o_valid and hold_sel stay stable. No data is altered or dropped under backpressure.
- o_valid = hold_valid ? (1 << hold_sel) : 0. It is never multi-hot.
- o_data holds the last accepted value after draining; it is not cleared.
- cur_sel advances only on an input transfer in mode 1: cur_sel <= (cur_sel == NCH-1) ? 0 : cur_sel + 1. It wraps at NCH-1, not at 2**SELW-1.
- In mode 0, cur_sel holds. A mode switch neither resets cur_sel nor affects the held beat.
- In mode 1, s is ignored and err never fires.
- o_ready bits of non-selected channels are ignored.
- err is a registered pulse, 0 in all other cycles.

Test Plan:
- Addressed sweep: mode=0, o_ready all 1, i_valid=1, i_data=8'hA5, s stepping 0..7 on successive cycles -> o_valid = 8'h01, 02, 04, ..., 80, each one cycle after acceptance; o_data = 8'hA5; i_ready stays 1 (full throughput).
- Backpressure: mode=0, s=3, i_data=8'h3C accepted, o_ready[3]=0 for 4 cycles, next i_data=8'h5A pending -> o_valid = 8'h08 and o_data = 8'h3C held; i_ready = 0. Raise o_ready[3] -> 8'h3C consumed and 8'h5A accepted in the same edge.
- Round-robin wrap: mode=1, 10 beats with data 0..9, all ready -> channels 0,1,...,7,0,1 receive data 0..9; cur_sel = 2 at end.
- Out-of-range: NCH=6, SELW=3, mode=0, s=7, i_valid=1 -> err = 1 for exactly one cycle; o_valid = 0; i_ready stays 1. A following beat with s=5 gives o_valid = 6'b100000.
- Reset mid-operation: hold full on channel 2 with o_ready[2]=0 and cur_sel=5; assert rst between clock edges -> o_valid = 0, cur_sel = 0, i_ready = 0 immediately. After release, the first beat in mode 1 goes to channel 0.
